// File: rtl/call_scheduler.sv
// call_scheduler: SCAN-ordered elevator call latching, target selection and door dwell timing.
module call_scheduler #(
  parameter int DOOR_TICKS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] call_req,
  input  logic [1:0] cur_floor,
  input  logic       door_ok,
  input  logic       alarm,
  output logic [1:0] target,
  output logic       target_valid,
  output logic [1:0] dir,
  output logic [2:0] pending,
  output logic       door_open
);
  typedef enum logic [1:0] {IDLE, MOVE, DOOR, HALT} state_t;
  state_t state_q, state_d;
  logic [2:0] pending_q, pending_d, floor_m, latch_m, pend_n;
  logic [1:0] target_q, target_d, dir_q, dir_d, pick;
  logic [3:0] timer_q, timer_d;
  logic door_st, floor_hit;
  // Keep going in dir, else reverse, else serve the current floor; from idle: here, then up, then down.
  function automatic logic [1:0] scan(input logic [1:0] d, input logic [1:0] f, input logic [2:0] p);
    logic [1:0] up, dn;
    logic here;
    up = (f == 2'd1 && p[1]) ? 2'd2 : (f != 2'd3 && f != 2'd0 && p[2]) ? 2'd3 : 2'd0;
    dn = (f == 2'd3 && p[1]) ? 2'd2 : (f >= 2'd2 && p[0]) ? 2'd1 : 2'd0;
    here = (f == 2'd1 && p[0]) || (f == 2'd2 && p[1]) || (f == 2'd3 && p[2]);
    if (d == 2'b10) return dn != 2'd0 ? dn : up != 2'd0 ? up : here ? f : 2'd0;
    if (d == 2'b01) return up != 2'd0 ? up : dn != 2'd0 ? dn : here ? f : 2'd0;
    return here ? f : up != 2'd0 ? up : dn;
  endfunction
  function automatic logic [1:0] towards(input logic [1:0] f, input logic [1:0] t);
    return t > f ? 2'b01 : t < f ? 2'b10 : 2'b00;
  endfunction
  always_comb begin
    floor_m = cur_floor == 2'd0 ? 3'b000 : 3'b001 << (cur_floor - 2'd1);
    door_st = state_q == IDLE || state_q == DOOR;
    latch_m = state_q == HALT ? 3'b000 : door_st ? call_req & ~floor_m : call_req;
    floor_hit = door_st && |(call_req & floor_m);
    pend_n = pending_q | latch_m;
    pick = scan(dir_q, cur_floor, pend_n);
    state_d = state_q;
    pending_d = pend_n;
    target_d = target_q;
    dir_d = dir_q;
    timer_d = timer_q;
    if (alarm) begin
      state_d = HALT;
      target_d = 2'd0;
      dir_d = 2'b00;
      timer_d = 4'd0;
    end else if (state_q == HALT) begin
      state_d = IDLE;
    end else if (cur_floor != 2'd0) begin
      case (state_q)
        IDLE: begin
          if (floor_hit) begin
            state_d = DOOR;
            timer_d = 4'(DOOR_TICKS);
          end else if (|pend_n) begin
            state_d = MOVE;
            target_d = pick;
            dir_d = towards(cur_floor, pick);
          end
        end
        MOVE: begin
          if (cur_floor == target_q) begin
            pending_d = pend_n & ~floor_m;
            state_d = DOOR;
            timer_d = 4'(DOOR_TICKS);
            target_d = 2'd0;
          end else begin
            target_d = pick;
            dir_d = towards(cur_floor, pick);
          end
        end
        DOOR: begin
          if (floor_hit) begin
            timer_d = 4'(DOOR_TICKS);
          end else if (door_ok && timer_q > 4'd1) begin
            timer_d = timer_q - 4'd1;
          end else if (door_ok) begin
            timer_d = 4'd0;
            state_d = |pend_n ? MOVE : IDLE;
            target_d = |pend_n ? pick : 2'd0;
            dir_d = |pend_n ? towards(cur_floor, pick) : 2'b00;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pending_q <= 3'b000;
      target_q <= 2'd0;
      dir_q <= 2'b00;
      timer_q <= 4'd0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      target_q <= target_d;
      dir_q <= dir_d;
      timer_q <= timer_d;
    end
  end
  assign target = target_q;
  assign target_valid = state_q == MOVE;
  assign dir = dir_q;
  assign pending = pending_q;
  assign door_open = state_q == DOOR;
endmodule

// File: tb/tb_call_scheduler.sv
// tb_call_scheduler: vector table, corner sequences and a randomized run against a floor-level model.
module tb_call_scheduler;
  localparam int DT = 3;
  localparam int M_IDLE = 0, M_MOVE = 1, M_DOOR = 2, M_HALT = 3;
  logic clk = 1'b0;
  logic reset, door_ok, alarm, target_valid, door_open;
  logic [2:0] call_req, pending;
  logic [1:0] cur_floor, target, dir;
  int n_tests = 0, n_fail = 0;
  typedef struct {
    logic rst; logic [2:0] call; logic [1:0] flr; logic ok; logic al;
    logic [1:0] tgt; logic tv; logic [1:0] dr; logic [2:0] pend; logic door;
  } vec_t;
  vec_t vq[$];
  int m_st, m_tgt, m_dir, m_tmr;
  bit m_p[1:3];
  call_scheduler #(.DOOR_TICKS(DT)) dut (
    .clk(clk), .reset(reset), .call_req(call_req), .cur_floor(cur_floor),
    .door_ok(door_ok), .alarm(alarm), .target(target), .target_valid(target_valid),
    .dir(dir), .pending(pending), .door_open(door_open)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end
  function automatic logic [8:0] outs();
    return {target, target_valid, dir, pending, door_open};
  endfunction
  task automatic chk(input string nm, input logic [8:0] got, input logic [8:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {tgt,tv,dir,pend,door}=%b want %b", nm, got, exp);
    end
  endtask
  task automatic add(input logic rst, input logic [2:0] call, input logic [1:0] flr, input logic ok,
                     input logic al, input logic [1:0] tgt, input logic tv, input logic [1:0] dr,
                     input logic [2:0] pend, input logic door);
    vec_t v;
    v = '{rst, call, flr, ok, al, tgt, tv, dr, pend, door};
    vq.push_back(v);
  endtask
  task automatic cyc(input logic rst, input logic [2:0] call, input logic [1:0] flr, input logic ok, input logic al);
    reset = rst; call_req = call; cur_floor = flr; door_ok = ok; alarm = al;
    @(posedge clk);
    @(negedge clk);
  endtask
  function automatic int sgn(input int x);
    return x > 0 ? 1 : x < 0 ? -1 : 0;
  endfunction
  function automatic int absv(input int x);
    return x < 0 ? -x : x;
  endfunction
  // Nearest pending floor: ahead in d, else behind, else here; with d=0 nearest overall, ties upward.
  function automatic int pick(input int d, input int f);
    int best = 0, bd = 99;
    if (d == 0) begin
      for (int i = 3; i >= 1; i--)
        if (m_p[i] && absv(i - f) < bd) begin best = i; bd = absv(i - f); end
      return best;
    end
    for (int i = 1; i <= 3; i++)
      if (m_p[i] && (i - f) * d > 0 && absv(i - f) < bd) begin best = i; bd = absv(i - f); end
    if (best == 0)
      for (int i = 1; i <= 3; i++)
        if (m_p[i] && (i - f) * d < 0 && absv(i - f) < bd) begin best = i; bd = absv(i - f); end
    if (best == 0 && f >= 1 && m_p[f]) best = f;
    return best;
  endfunction
  function automatic bit any_p();
    return m_p[1] | m_p[2] | m_p[3];
  endfunction
  task automatic depart(input int f);
    m_tgt = pick(m_dir, f);
    m_dir = sgn(m_tgt - f);
    m_st = M_MOVE;
  endtask
  task automatic model_step(input logic rst, input logic [2:0] call, input int f, input logic ok, input logic al);
    bit hit = 0;
    if (rst) begin
      m_st = M_IDLE; m_tgt = 0; m_dir = 0; m_tmr = 0;
      for (int i = 1; i <= 3; i++) m_p[i] = 0;
      return;
    end
    for (int i = 1; i <= 3; i++)
      if (call[i-1] && m_st != M_HALT) begin
        if ((m_st == M_IDLE || m_st == M_DOOR) && i == f) hit = 1;
        else m_p[i] = 1;
      end
    if (al) begin
      m_st = M_HALT; m_tgt = 0; m_dir = 0; m_tmr = 0;
    end else if (m_st == M_HALT) begin
      m_st = M_IDLE;
    end else if (f != 0) begin
      if (m_st == M_IDLE) begin
        if (hit) begin m_st = M_DOOR; m_tmr = DT; end
        else if (any_p()) depart(f);
      end else if (m_st == M_MOVE) begin
        if (f == m_tgt) begin m_p[f] = 0; m_st = M_DOOR; m_tmr = DT; end
        else begin m_tgt = pick(m_dir, f); m_dir = sgn(m_tgt - f); end
      end else if (m_st == M_DOOR) begin
        if (hit) m_tmr = DT;
        else if (ok && m_tmr > 1) m_tmr--;
        else if (ok && any_p()) depart(f);
        else if (ok) begin m_st = M_IDLE; m_dir = 0; end
      end
    end
  endtask
  function automatic logic [8:0] model_outs();
    logic [1:0] t, d;
    t = m_st == M_MOVE ? 2'(m_tgt) : 2'd0;
    d = m_dir > 0 ? 2'b01 : m_dir < 0 ? 2'b10 : 2'b00;
    return {t, m_st == M_MOVE, d, m_p[3], m_p[2], m_p[1], m_st == M_DOOR};
  endfunction
  initial begin
    int n, fpos;
    logic r, o, a;
    logic [2:0] c;
    logic [1:0] fl;
    reset = 1'b1; call_req = 3'b000; cur_floor = 2'd1; door_ok = 1'b1; alarm = 1'b0;
    add(1'b1, 3'b000, 2'd1, 1'b1, 1'b0, 2'd0, 1'b0, 2'b00, 3'b000, 1'b0);
    add(1'b0, 3'b100, 2'd1, 1'b1, 1'b0, 2'd3, 1'b1, 2'b01, 3'b100, 1'b0);
    add(1'b0, 3'b010, 2'd1, 1'b1, 1'b0, 2'd2, 1'b1, 2'b01, 3'b110, 1'b0);
    add(1'b0, 3'b000, 2'd2, 1'b1, 1'b0, 2'd0, 1'b0, 2'b01, 3'b100, 1'b1);
    add(1'b0, 3'b000, 2'd2, 1'b1, 1'b0, 2'd0, 1'b0, 2'b01, 3'b100, 1'b1);
    add(1'b0, 3'b000, 2'd2, 1'b1, 1'b0, 2'd0, 1'b0, 2'b01, 3'b100, 1'b1);
    add(1'b0, 3'b000, 2'd2, 1'b1, 1'b0, 2'd3, 1'b1, 2'b01, 3'b100, 1'b0);
    add(1'b0, 3'b000, 2'd3, 1'b1, 1'b0, 2'd0, 1'b0, 2'b01, 3'b000, 1'b1);
    add(1'b0, 3'b001, 2'd3, 1'b0, 1'b0, 2'd0, 1'b0, 2'b01, 3'b001, 1'b1);
    add(1'b0, 3'b000, 2'd3, 1'b0, 1'b0, 2'd0, 1'b0, 2'b01, 3'b001, 1'b1);
    add(1'b0, 3'b000, 2'd3, 1'b1, 1'b0, 2'd0, 1'b0, 2'b01, 3'b001, 1'b1);
    add(1'b0, 3'b100, 2'd3, 1'b1, 1'b0, 2'd0, 1'b0, 2'b01, 3'b001, 1'b1);
    add(1'b0, 3'b000, 2'd3, 1'b1, 1'b0, 2'd0, 1'b0, 2'b01, 3'b001, 1'b1);
    add(1'b0, 3'b000, 2'd3, 1'b1, 1'b0, 2'd0, 1'b0, 2'b01, 3'b001, 1'b1);
    add(1'b0, 3'b000, 2'd3, 1'b1, 1'b0, 2'd1, 1'b1, 2'b10, 3'b001, 1'b0);
    add(1'b0, 3'b000, 2'd3, 1'b1, 1'b1, 2'd0, 1'b0, 2'b00, 3'b001, 1'b0);
    add(1'b0, 3'b010, 2'd3, 1'b1, 1'b0, 2'd0, 1'b0, 2'b00, 3'b001, 1'b0);
    add(1'b0, 3'b000, 2'd3, 1'b1, 1'b0, 2'd1, 1'b1, 2'b10, 3'b001, 1'b0);
    add(1'b0, 3'b000, 2'd0, 1'b1, 1'b0, 2'd1, 1'b1, 2'b10, 3'b001, 1'b0);
    add(1'b0, 3'b010, 2'd2, 1'b1, 1'b0, 2'd1, 1'b1, 2'b10, 3'b011, 1'b0);
    add(1'b0, 3'b001, 2'd1, 1'b1, 1'b0, 2'd0, 1'b0, 2'b10, 3'b010, 1'b1);
    add(1'b1, 3'b000, 2'd1, 1'b1, 1'b0, 2'd0, 1'b0, 2'b00, 3'b000, 1'b0);
    @(negedge clk);
    foreach (vq[i]) begin
      cyc(vq[i].rst, vq[i].call, vq[i].flr, vq[i].ok, vq[i].al);
      chk($sformatf("vec%0d", i), outs(), {vq[i].tgt, vq[i].tv, vq[i].dr, vq[i].pend, vq[i].door});
    end
    // Door held by overload, then exactly DT more open cycles.
    cyc(1'b1, 3'b000, 2'd1, 1'b1, 1'b0);
    cyc(1'b0, 3'b001, 2'd1, 1'b1, 1'b0);
    chk("door_entry", outs(), {2'd0, 1'b0, 2'b00, 3'b000, 1'b1});
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 3'b000, 2'd1, 1'b0, 1'b0);
      chk("door_hold", {8'd0, door_open}, 9'd1);
    end
    n = 0;
    while (door_open && n < 20) begin
      cyc(1'b0, 3'b000, 2'd1, 1'b1, 1'b0);
      n++;
    end
    chk("door_dwell", 9'(n), 9'(DT));
    // Alarm coincident with arrival keeps the pending bit; recovery heads to the same floor.
    cyc(1'b1, 3'b000, 2'd1, 1'b1, 1'b0);
    cyc(1'b0, 3'b010, 2'd1, 1'b1, 1'b0);
    cyc(1'b0, 3'b000, 2'd2, 1'b1, 1'b1);
    chk("alarm_arrival", outs(), {2'd0, 1'b0, 2'b00, 3'b010, 1'b0});
    cyc(1'b0, 3'b000, 2'd2, 1'b1, 1'b0);
    chk("halt_to_idle", outs(), {2'd0, 1'b0, 2'b00, 3'b010, 1'b0});
    cyc(1'b0, 3'b000, 2'd2, 1'b1, 1'b0);
    chk("resume_move", outs(), {2'd2, 1'b1, 2'b00, 3'b010, 1'b0});
    cyc(1'b0, 3'b000, 2'd2, 1'b1, 1'b0);
    chk("resume_arrive", outs(), {2'd0, 1'b0, 2'b00, 3'b000, 1'b1});
    // SCAN from floor 2 going up with floors 1 and 3 pending.
    cyc(1'b1, 3'b000, 2'd2, 1'b1, 1'b0);
    cyc(1'b0, 3'b100, 2'd2, 1'b1, 1'b0);
    chk("scan_up", outs(), {2'd3, 1'b1, 2'b01, 3'b100, 1'b0});
    cyc(1'b0, 3'b001, 2'd2, 1'b1, 1'b0);
    chk("scan_keep", outs(), {2'd3, 1'b1, 2'b01, 3'b101, 1'b0});
    for (int k = 0; k < DT; k++) cyc(1'b0, 3'b000, 2'd3, 1'b1, 1'b0);
    chk("scan_door3", outs(), {2'd0, 1'b0, 2'b01, 3'b001, 1'b1});
    cyc(1'b0, 3'b000, 2'd3, 1'b1, 1'b0);
    chk("scan_reverse", outs(), {2'd1, 1'b1, 2'b10, 3'b001, 1'b0});
    // Randomized run against the model; the floor follows the model's target.
    fpos = 1;
    cyc(1'b1, 3'b000, 2'd1, 1'b1, 1'b0);
    model_step(1'b1, 3'b000, 1, 1'b1, 1'b0);
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 199) == 0;
      c = {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0};
      o = $urandom_range(0, 4) != 0;
      a = $urandom_range(0, 39) == 0;
      if (m_st == M_MOVE && $urandom_range(0, 1) == 1) fpos += sgn(m_tgt - fpos);
      fl = $urandom_range(0, 19) == 0 ? 2'd0 : 2'(fpos);
      cyc(r, c, fl, o, a);
      model_step(r, c, int'(fl), o, a);
      chk($sformatf("rand%0d", k), outs(), model_outs());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/call_scheduler.md
CALL_SCHEDULER -- requirements
Module: call_scheduler

Interface
REQ-001 Parameter DOOR_TICKS, default 3: door-open dwell in clk cycles; legal range 1..15.
REQ-002 clk  in  1  single clock, 1 Hz elevator tick; all state changes on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 call_req  in  3  one-cycle debounced call pulses; bit0 = floor 1, bit1 = floor 2, bit2 = floor 3.
REQ-005 cur_floor  in  2  current floor from the floor FSM; 2'd1..2'd3 valid, 2'd0 invalid.
REQ-006 door_ok  in  1  load permission from the people counter; 0 = overload, door held.
REQ-007 alarm  in  1  overload alarm; 1 = halt.
REQ-008 target  out  2  floor the floor FSM moves toward; 2'd0 when none.
REQ-009 target_valid  out  1  target is meaningful; asserted only in MOVE.
REQ-010 dir  out  2  2'b01 up, 2'b10 down, 2'b00 idle; drives the direction matrix.
REQ-011 pending  out  3  latched outstanding calls, same bit mapping as call_req.
REQ-012 door_open  out  1  door open, asserted only in DOOR.

Function
REQ-013 FSM states: IDLE, MOVE, DOOR, HALT; exactly one active.
REQ-014 A call_req bit sets its pending bit on the next edge, except:
- in IDLE/DOOR when the bit equals cur_floor: it is not latched; it sets or reloads the door timer instead.
- in HALT: all calls are ignored.
REQ-015 Pending bits clear only on arrival (REQ-018) or reset; repeated calls are idempotent.
REQ-016 IDLE, pending==0: stay, dir=00.
REQ-017 IDLE, pending!=0: select target by REQ-020, go to MOVE, set dir toward target.
REQ-018 MOVE, cur_floor==target:
- clear pending[target-1];
- load timer with DOOR_TICKS;
- go to DOOR; target_valid drops on the same edge.
REQ-019 DOOR behaviour:
- timer decrements once per cycle while door_ok=1;
- timer holds at its current value while door_ok=0;
- timer reaches 0 with pending==0: go to IDLE, dir=00;
- timer reaches 0 with pending!=0: go to MOVE with a new target per REQ-020.
REQ-020 Target selection (SCAN):
- continue in the current dir to the nearest pending floor beyond cur_floor in that direction;
- if none, reverse and take the nearest pending floor in the opposite direction;
- from dir=00, the nearest pending floor wins; a tie goes up.
REQ-021 MOVE with a new call between cur_floor and target in the same direction: retarget to the nearer floor on the next edge (intermediate stop).
REQ-022 cur_floor==2'd0: hold state; no target change, no arrival.
REQ-023 alarm=1 in any state: go to HALT on the next edge.
- HALT outputs: target_valid=0, dir=00, door_open=0.
- pending is retained.
REQ-024 HALT with alarm=0: go to IDLE on the next edge.
REQ-025 Simultaneous alarm and arrival: alarm wins; the pending bit is not cleared.
REQ-026 Simultaneous call_req and arrival for the same floor: the bit ends cleared.
REQ-027 All outputs are registered; no combinational input-to-output path.

Reset
REQ-028 reset=1 takes priority over all inputs; effective on the next edge.
REQ-029 Reset values: state IDLE, pending=000, target=0, target_valid=0, dir=00, door_open=0, timer=0.
REQ-030 Reset mid-MOVE or mid-DOOR discards all calls and timer progress.

Verification
REQ-031 cur_floor=1, call_req=100 pulse -> next edge: pending=100, target=3, dir=01, target_valid=1.
REQ-032 MOVE toward 3 from floor 1, call_req=010 -> target=2; at cur_floor=2:
- door_open=1 for 3 cycles;
- pending=100;
- then target=3, dir=01.
REQ-033 cur_floor=2, dir=01, pending=101 -> floor 3 served first, then target=1, dir=10.
REQ-034 DOOR with door_ok=0 for 5 cycles -> door_open stays 1; then exactly 3 more cycles after door_ok=1.
REQ-035 alarm pulse mid-MOVE:
- alarm=1 -> HALT, dir=00, pending unchanged;
- alarm=0 -> IDLE, then MOVE to the same target.
REQ-036 reset asserted in DOOR with pending=011 -> all outputs reach REQ-029 values one edge later.
